// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and reset constants for mem_port_arbiter
// MEM_ARB_ROUND_ROBIN_EN adds the round-robin pointer reset constant.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } arb_grant_t;

  localparam arb_state_t STATE_RST = IDLE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // The pointer names the port that wins the next contested grant.
  localparam arb_grant_t RR_PTR_RST = GRANT_DATA;
`endif

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU instruction/data ports and shared memory port bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_read;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_resp;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  data_read;
  logic                  data_write;
  logic [DATA_W/8-1:0]   data_mbe;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_resp;
  logic [DATA_W-1:0]     data_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic                  mem_resp;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata,
    input  mem_resp, mem_rdata,
    output inst_resp, inst_rdata, data_resp, data_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
  );

  modport master (
    output inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata,
    output mem_resp, mem_rdata,
    input  inst_resp, inst_rdata, data_resp, data_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
  );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// rtl/mem_port_arbiter_select.sv - winner selection between instruction and data ports
// MEM_ARB_ROUND_ROBIN_EN: alternate contested grants; otherwise data has fixed priority.
module arb_select
  import mem_arb_types::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       grant_en,
  output logic       grant,
  output arb_grant_t winner
);

  assign grant = grant_en & (inst_req | data_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_grant_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inst_req && data_req) begin
      winner = ptr_q;
    end else if (data_req) begin
      winner = GRANT_DATA;
    end else begin
      winner = GRANT_INST;
    end
    // Only a contested grant moves the pointer, handing the next tie to the loser.
    if (grant_en && inst_req && data_req) begin
      ptr_d = (ptr_q == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= RR_PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign winner = data_req ? GRANT_DATA : GRANT_INST;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises CPU instruction/data requests onto one memory port
// MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first arbitration.
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int MBE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              abandon_q, abandon_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MBE_W-1:0]  mem_mbe_q, mem_mbe_d;
  logic              inst_req, data_req, port_req, grant, resp_ok;
  logic              inst_resp, data_resp;
  arb_grant_t        winner;

  assign inst_req = bus.inst_read;
  assign data_req = bus.data_read | bus.data_write;
  assign port_req = (state_q == DATA) ? data_req : inst_req;

  arb_select u_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .inst_req (inst_req),
    .data_req (data_req),
    .grant_en (state_q == IDLE),
    .grant    (grant),
    .winner   (winner)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mbe_d   = mem_mbe_q;
    abandon_d   = abandon_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          abandon_d = 1'b0;
          if (winner == GRANT_DATA) begin
            state_d     = DATA;
            mem_read_d  = bus.data_read & ~bus.data_write;
            mem_write_d = bus.data_write;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_wdata;
            mem_mbe_d   = bus.data_mbe;
          end else begin
            state_d     = INST;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = bus.inst_addr;
            mem_wdata_d = '0;
            mem_mbe_d   = '0;
          end
        end
      end
      INST, DATA: begin
        // Once the port lets go, the eventual memory response belongs to nobody.
        if (!port_req) begin
          abandon_d = 1'b1;
        end
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_mbe_d   = '0;
          abandon_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_RST;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mbe_q   <= '0;
      abandon_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mbe_q   <= mem_mbe_d;
      abandon_q   <= abandon_d;
    end
  end

  assign resp_ok   = bus.mem_resp & port_req & ~abandon_q & ~rst;
  assign inst_resp = resp_ok & (state_q == INST);
  assign data_resp = resp_ok & (state_q == DATA);

  assign bus.inst_resp  = inst_resp;
  assign bus.data_resp  = data_resp;
  assign bus.inst_rdata = inst_resp ? bus.mem_rdata : '0;
  assign bus.data_rdata = data_resp ? bus.mem_rdata : '0;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_mbe    = mem_mbe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench with a transaction-order model
// MEM_ARB_ROUND_ROBIN_EN switches the model to alternating contested grants.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_inst;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_contest_data;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit data_wins_contest();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return !last_contest_data;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_port(input txn_t t);
    if (t.is_inst) begin
      bus.inst_read = 1'b1;
      bus.inst_addr = t.addr;
    end else begin
      bus.data_read  = t.rd;
      bus.data_write = t.wr;
      bus.data_addr  = t.addr;
      bus.data_wdata = t.wdata;
      bus.data_mbe   = t.mbe;
    end
  endtask

  task automatic release_port(input txn_t t);
    if (t.is_inst) begin
      bus.inst_read = 1'b0;
    end else begin
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
    end
  endtask

  function automatic txn_t rand_txn(input bit is_inst);
    txn_t t;
    t.is_inst = is_inst;
    t.addr    = $urandom & 32'hFFFF_FFFC;
    t.wdata   = $urandom;
    t.mbe     = 4'($urandom_range(0, 15));
    t.wr      = is_inst ? 1'b0 : 1'($urandom_range(0, 1));
    t.rd      = is_inst ? 1'b0 : (t.wr ? 1'($urandom_range(0, 1)) : 1'b1);
    return t;
  endfunction

  // Call just after a rising edge with the request already driven; returns at the gap cycle's negedge.
  task automatic serve(input txn_t t, input int lat, input logic [31:0] rdata,
                       input bit drop_early, input string nm, output int waited);
    logic [69:0] exp_mem;
    logic [65:0] exp_rsp;
    exp_mem = t.is_inst ? {1'b1, 1'b0, t.addr, 32'h0, 4'h0}
                        : {t.rd & ~t.wr, t.wr, t.addr, t.wdata, t.mbe};
    waited = 0;
    @(negedge clk);
    while (!(bus.mem_read || bus.mem_write) && waited < 16) begin
      step();
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe} !== exp_mem) begin
      n_fail++;
      $display("FAIL %s grant: got %h expected %h", nm,
               {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe}, exp_mem);
    end
    for (int i = 0; i < lat; i++) begin
      step();
      bus.mem_rdata = $urandom;
      if (drop_early && i == 0) release_port(t);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe,
           bus.inst_resp, bus.data_resp} !== {exp_mem, 2'b00}) begin
        n_fail++;
        $display("FAIL %s hold: got %h expected %h", nm,
                 {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe,
                  bus.inst_resp, bus.data_resp}, {exp_mem, 2'b00});
      end
    end
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rdata;
    exp_rsp = drop_early ? 66'h0 : (t.is_inst ? {2'b10, rdata, 32'h0} : {2'b01, 32'h0, rdata});
    @(negedge clk);
    n_checks++;
    if ({bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata} !== exp_rsp) begin
      n_fail++;
      $display("FAIL %s resp: got %h expected %h", nm,
               {bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata}, exp_rsp);
    end
    step();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = $urandom;
    release_port(t);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.inst_resp, bus.data_resp,
         bus.inst_rdata, bus.data_rdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL %s gap: got %h expected 0", nm,
               {bus.mem_read, bus.mem_write, bus.inst_resp, bus.data_resp,
                bus.inst_rdata, bus.data_rdata});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.inst_read = 1'b0; bus.inst_addr = '0;
    bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_mbe = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = 32'h1234_5678;
    last_contest_data = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe, bus.inst_resp,
         bus.data_resp, bus.inst_rdata, bus.data_rdata} !== 136'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe,
                bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata});
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_inst_read();
    txn_t t;
    int   w;
    t = '{is_inst: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'h60, wdata: 32'h0, mbe: 4'h0};
    step();
    drive_port(t);
    serve(t, 1, 32'h00A0_0093, 1'b0, "inst_read", w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL inst_read_latency: got %0d cycles expected 1", w);
    end
  endtask

  task automatic test_data_write();
    txn_t t;
    int   w;
    t = '{is_inst: 1'b0, rd: 1'b0, wr: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF, mbe: 4'b0011};
    step();
    drive_port(t);
    serve(t, 2, 32'h0BAD_F00D, 1'b0, "data_write", w);
  endtask

  task automatic test_read_write_both();
    txn_t t;
    int   w;
    t = '{is_inst: 1'b0, rd: 1'b1, wr: 1'b1, addr: 32'h204, wdata: 32'hCAFE_0001, mbe: 4'b1111};
    step();
    drive_port(t);
    serve(t, 0, 32'h5555_AAAA, 1'b0, "rw_both", w);
  endtask

  task automatic test_simultaneous();
    txn_t ti, td, first, second;
    int   w;
    for (int r = 0; r < 2; r++) begin
      ti = rand_txn(1'b1);
      td = rand_txn(1'b0);
      step();
      drive_port(ti);
      drive_port(td);
      if (data_wins_contest()) begin first = td; second = ti; end
      else begin first = ti; second = td; end
      last_contest_data = !first.is_inst;
      serve(first, 1, $urandom, 1'b0, "contest_first", w);
      step();
      serve(second, 1, $urandom, 1'b0, "contest_second", w);
      n_checks++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL contest_regrant: got %0d cycles expected 0", w);
      end
    end
  endtask

  task automatic test_abandon();
    txn_t t;
    int   w;
    t = rand_txn(1'b1);
    step();
    drive_port(t);
    serve(t, 3, 32'hFEED_FACE, 1'b1, "abandon", w);
    t = rand_txn(1'b0);
    step();
    drive_port(t);
    serve(t, 1, $urandom, 1'b0, "after_abandon", w);
  endtask

  task automatic test_reset_mid();
    txn_t t;
    t = '{is_inst: 1'b0, rd: 1'b0, wr: 1'b1, addr: 32'h3C0, wdata: 32'h1111_2222, mbe: 4'hF};
    step();
    drive_port(t);
    step();
    @(negedge clk);
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got mem_write %b expected 1", bus.mem_write);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    release_port(t);
    last_contest_data = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe,
         bus.data_resp} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got %h expected 0",
               {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_mbe, bus.data_resp});
    end
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h9999_9999;
    @(negedge clk);
    n_checks++;
    if ({bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_mid_late_resp: got %h expected 0",
               {bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata});
    end
    step();
    bus.mem_resp = 1'b0;
  endtask

  task automatic test_random();
    txn_t q[$];
    txn_t ti, td;
    int   kind, w;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      ti = rand_txn(1'b1);
      td = rand_txn(1'b0);
      q.delete();
      if (kind == 0) q.push_back(ti);
      else if (kind == 1) q.push_back(td);
      else begin
        if (data_wins_contest()) begin q.push_back(td); q.push_back(ti); end
        else begin q.push_back(ti); q.push_back(td); end
        last_contest_data = !q[0].is_inst;
      end
      step();
      foreach (q[k]) drive_port(q[k]);
      foreach (q[k]) begin
        if (k > 0) step();
        serve(q[k], $urandom_range(0, 3), $urandom, 1'b0, "random", w);
        n_checks++;
        if (w !== ((k == 0) ? 1 : 0)) begin
          n_fail++;
          $display("FAIL random_latency: got %0d cycles expected %0d", w, (k == 0) ? 1 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_read_write_both();
    test_simultaneous();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
